qu_rob_ctrl: RTL
================

// Module: qu_rob_ctrl
// PURPOSE
//  Reorder-buffer controller for the Qu out-of-order core: owns ROB_DEPTH rob_cell_t entries as a circular buffer.
//  Allocates entries at dispatch, tracks PENDING->EXECUTE->RETIRED per entry, and commits in program order.
//  Sits between rename/dispatch (alloc), reservation stations (issue), the CDB (writeback) and the physical RF (commit).
// PARAMETERS
//  DEPTH       ROB_DEPTH (8)        number of entries; power of two, >=2
//  ADDR_W      $clog2(DEPTH) (3)    entry index width (rob_addr_t)
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  rst          in   1          synchronous reset, active-high
//  flush        in   1          discard all entries (mispredict/exception)
//  alloc_valid  in   1          dispatch requests an entry
//  alloc_dest   in   7          physical destination (phy_rf_addr_t)
//  alloc_ready  out  1          entry available
//  alloc_addr   out  ADDR_W     index granted (= tail); valid with alloc_ready
//  issue_valid  in   1          RS issued the op tagged issue_addr
//  issue_addr   in   ADDR_W     entry moving PENDING->EXECUTE
//  wb_valid     in   1          CDB result broadcast
//  wb_addr      in   ADDR_W     entry being written back
//  wb_value     in   32         result value
//  commit_valid out  1          head entry ready to retire
//  commit_ready in   1          physical RF accepts commit
//  commit_dest  out  7          head dest
//  commit_value out  32         head value
//  commit_addr  out  ADDR_W     head index
//  rob_count    out  ADDR_W+1   occupied entries, 0..DEPTH
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all states EMPTY, value/dest 0 -> alloc_ready=1, commit_valid=0, rob_count=0.
//  - Alloc: alloc_ready = (count!=DEPTH). On alloc_valid&&alloc_ready: cell[tail]={0,alloc_dest,PENDING}, tail++ (mod DEPTH).
//  - alloc_ready uses registered count only; a same-cycle commit never frees a slot for that cycle's alloc.
//  - Issue: if state[issue_addr]==PENDING -> EXECUTE next cycle; any other state ignored.
//  - Writeback: if state[wb_addr]==EXECUTE -> value<=wb_value, state<=RETIRED; other states ignored.
//  - Commit: commit_valid = (state[head]==RETIRED), combinational from registered state; outputs show cell[head].
//    On commit_valid&&commit_ready: state[head]<=EMPTY, head++ (mod DEPTH). Max one commit, one alloc per cycle.
//  - count: +1 on alloc only, -1 on commit only, unchanged on both or neither; head/tail wrap DEPTH-1 -> 0.
//  - Full (count==DEPTH, head==tail): alloc_ready=0, alloc_valid ignored; issue/wb/commit still operate.
//  - Empty (count==0): commit_valid=0; alloc proceeds normally.
//  - Same-entry same-cycle events: issue and wb on same addr -> only issue acts (wb sees PENDING, dropped).
//    Alloc to tail and wb to same index cannot collide (tail entry is EMPTY, wb ignored).
//  - Flush: priority over alloc/issue/wb/commit; next cycle identical to reset state. No commit occurs in a flush cycle.
//  - rst priority over flush; reset mid-operation discards all entries, no commit outputs generated.
//  - Latency: alloc->PENDING visible 1 cycle; wb->commit_valid 1 cycle (see CONFIGURATION).
// CONFIGURATION
//  QU_ROB_COMMIT_BYPASS_EN defined: when wb_valid hits head (wb_addr==head, state EXECUTE), commit_valid=1 the same
//    cycle with commit_value=wb_value; on commit_ready the entry goes directly to EMPTY (never stored RETIRED).
//  Undefined: wb->commit_valid is always exactly 1 cycle; no combinational path from wb_* to commit_*.
// TESTING
//  1 Reset then 8 allocs dest 10..17 -> alloc_addr 0..7, rob_count 8, alloc_ready=0; 9th alloc ignored, tail stays 0.
//  2 Alloc dest 5 at addr 0, issue 0, wb 0 value 0xDEADBEEF -> next cycle commit_valid=1, dest 5, value 0xDEADBEEF;
//    commit_ready=1 -> count 0, commit_valid=0.
//  3 Alloc 0,1; issue+wb entry 1 first -> commit_valid stays 0 until entry 0 written back; then commits 0 then 1 in order.
//  4 Full ROB, commit head and alloc_valid same cycle -> count stays 7 next cycle (alloc refused), then alloc accepted, tail wraps to 0.
//  5 Three entries in flight, flush with alloc_valid, wb_valid high -> next cycle count 0, all EMPTY, alloc_addr 0.
//  6 wb to PENDING entry 2 (no issue) -> ignored, state stays PENDING; with BYPASS_EN, wb to EXECUTE head -> same-cycle commit_valid.

Source files
------------

// File: rtl/qu_rob_ctrl_if.sv
// Handshake bundle between the Qu ROB controller and dispatch, RS, CDB and physical RF.
// master = surrounding pipeline, slave = ROB controller.
interface qu_rob_ctrl_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              flush;
  logic              alloc_valid;
  logic [6:0]        alloc_dest;
  logic              alloc_ready;
  logic [ADDR_W-1:0] alloc_addr;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_value;
  logic              commit_valid;
  logic              commit_ready;
  logic [6:0]        commit_dest;
  logic [31:0]       commit_value;
  logic [ADDR_W-1:0] commit_addr;
  logic [ADDR_W:0]   rob_count;

  modport master (
    output flush, alloc_valid, alloc_dest, issue_valid, issue_addr,
           wb_valid, wb_addr, wb_value, commit_ready,
    input  alloc_ready, alloc_addr, commit_valid, commit_dest,
           commit_value, commit_addr, rob_count
  );

  modport slave (
    input  flush, alloc_valid, alloc_dest, issue_valid, issue_addr,
           wb_valid, wb_addr, wb_value, commit_ready,
    output alloc_ready, alloc_addr, commit_valid, commit_dest,
           commit_value, commit_addr, rob_count
  );
endinterface

// File: rtl/qu_rob_ctrl.sv
// Reorder-buffer controller: circular buffer of DEPTH cells, in-order commit.
// Optional QU_ROB_COMMIT_BYPASS_EN: writeback to the head entry commits in the same cycle.
module qu_rob_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         rst,
  qu_rob_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PENDING,
    ST_EXECUTE,
    ST_RETIRED
  } cell_state_e;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  cell_state_e       state_q [DEPTH];
  cell_state_e       state_d [DEPTH];
  logic [6:0]        dest_q  [DEPTH];
  logic [6:0]        dest_d  [DEPTH];
  logic [31:0]       value_q [DEPTH];
  logic [31:0]       value_d [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic full, issue_hit, wb_hit, head_ready, commit_ok, commit_fire, alloc_fire;

  assign full      = (count_q == FULL_CNT);
  assign issue_hit = bus.issue_valid && (state_q[bus.issue_addr] == ST_PENDING);
  assign wb_hit    = bus.wb_valid && (state_q[bus.wb_addr] == ST_EXECUTE);

`ifdef QU_ROB_COMMIT_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit       = wb_hit && (bus.wb_addr == head_q);
  assign head_ready       = (state_q[head_q] == ST_RETIRED) || bypass_hit;
  assign bus.commit_value = bypass_hit ? bus.wb_value : value_q[head_q];
`else
  assign head_ready       = (state_q[head_q] == ST_RETIRED);
  assign bus.commit_value = value_q[head_q];
`endif

  // Suppressed during rst/flush so the RF never sees a commit that the ROB then discards.
  assign commit_ok   = head_ready && !rst && !bus.flush;
  assign commit_fire = commit_ok && bus.commit_ready;
  assign alloc_fire  = bus.alloc_valid && !full;

  assign bus.commit_valid = commit_ok;
  assign bus.commit_dest  = dest_q[head_q];
  assign bus.commit_addr  = head_q;
  assign bus.alloc_ready  = !full;
  assign bus.alloc_addr   = tail_q;
  assign bus.rob_count    = count_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    value_d = value_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (issue_hit) state_d[bus.issue_addr] = ST_EXECUTE;
    if (wb_hit) begin
      state_d[bus.wb_addr] = ST_RETIRED;
      value_d[bus.wb_addr] = bus.wb_value;
    end
    // Commit is applied after wb so a bypassed head goes straight to EMPTY.
    if (commit_fire) begin
      state_d[head_q] = ST_EMPTY;
      head_d          = head_q + 1'b1;
    end
    if (alloc_fire) begin
      state_d[tail_q] = ST_PENDING;
      dest_d[tail_q]  = bus.alloc_dest;
      value_d[tail_q] = '0;
      tail_d          = tail_q + 1'b1;
    end

    if (alloc_fire && !commit_fire) count_d = count_q + 1'b1;
    else if (commit_fire && !alloc_fire) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_EMPTY;
        dest_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      dest_q  <= dest_d;
      value_q <= value_d;
    end
  end

endmodule
